// File: rtl/sdf_bf_stage_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg: shared definitions for the streaming R2^2 SDF FFT pipeline stages.
//   FFT_WIDTH       default two's-complement component width
//   FFT_XW          widest (WIDTH+1)-bit operand fft_half_scale accepts
//   fft_half_scale  rounding half-scale, (v + 1) >>> 1, round-half-up
// Callers sign-extend their WIDTH+1 bit value to FFT_XW bits and keep the
// low WIDTH bits of the result, which always hold it exactly.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned FFT_WIDTH = 16;
    localparam int unsigned FFT_XW    = 33;

    function automatic logic signed [FFT_XW-1:0] fft_half_scale(
        input logic signed [FFT_XW-1:0] v
    );
        logic signed [FFT_XW-1:0] t;
        t = v + {{(FFT_XW-1){1'b0}}, 1'b1};
        return t >>> 1;
    endfunction

endpackage

// File: rtl/sdf_bf_stage_if.sv
// -----------------------------------------------------------------------------
// sdf_bf_stage_if: sample stream into and out of one SDF butterfly stage.
//   di_en/di_re/di_im  input sample valid and complex data
//   do_en/do_re/do_im  output sample valid and complex data
//   master  upstream producer / downstream consumer side
//   slave   the butterfly stage itself
// -----------------------------------------------------------------------------
interface sdf_bf_stage_if
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH
);

    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im
    );

endinterface

// File: rtl/sdf_bf_stage_core.sv
// -----------------------------------------------------------------------------
// sdf_bf_core: combinational radix-2 butterfly with rounding half-scale.
//   x0_*_i, x1_*_i  complex operands (WIDTH bits per component)
//   s_*_o           ((x0 + x1) + 1) >>> 1
//   d_*_o           ((x0 - x1) + 1) >>> 1
// Sums/differences are formed in WIDTH+1 bits so the scaled result never wraps.
// -----------------------------------------------------------------------------
module sdf_bf_core
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH
) (
    input  logic signed [WIDTH-1:0] x0_re_i,
    input  logic signed [WIDTH-1:0] x0_im_i,
    input  logic signed [WIDTH-1:0] x1_re_i,
    input  logic signed [WIDTH-1:0] x1_im_i,
    output logic signed [WIDTH-1:0] s_re_o,
    output logic signed [WIDTH-1:0] s_im_o,
    output logic signed [WIDTH-1:0] d_re_o,
    output logic signed [WIDTH-1:0] d_im_o
);

    logic signed [WIDTH:0] s_re;
    logic signed [WIDTH:0] s_im;
    logic signed [WIDTH:0] d_re;
    logic signed [WIDTH:0] d_im;

    always_comb begin
        s_re = {x0_re_i[WIDTH-1], x0_re_i} + {x1_re_i[WIDTH-1], x1_re_i};
        s_im = {x0_im_i[WIDTH-1], x0_im_i} + {x1_im_i[WIDTH-1], x1_im_i};
        d_re = {x0_re_i[WIDTH-1], x0_re_i} - {x1_re_i[WIDTH-1], x1_re_i};
        d_im = {x0_im_i[WIDTH-1], x0_im_i} - {x1_im_i[WIDTH-1], x1_im_i};

        s_re_o = WIDTH'(fft_half_scale(FFT_XW'(s_re)));
        s_im_o = WIDTH'(fft_half_scale(FFT_XW'(s_im)));
        d_re_o = WIDTH'(fft_half_scale(FFT_XW'(d_re)));
        d_im_o = WIDTH'(fft_half_scale(FFT_XW'(d_im)));
    end

endmodule

// File: rtl/sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// sdf_bf_stage: radix-2 single-path delay-feedback butterfly stage.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      sdf_bf_stage_if.slave: di_* sample in, do_* sample out
// Frames are 2M contiguous valid samples. The first half is parked in an
// M-deep feedback delay line; during the second half each input meets its
// partner M samples earlier, the scaled sum goes out directly and the scaled
// difference goes back into the delay line to drain during the next M cycles.
// Output latency is M+1 cycles; do_en is di_en delayed by M+1.
// -----------------------------------------------------------------------------
module sdf_bf_stage
    import fft_pkg::*;
#(
    parameter int unsigned M     = 32,
    parameter int unsigned WIDTH = FFT_WIDTH
) (
    input  logic          clock,
    input  logic          reset_n,
    sdf_bf_stage_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(M) + 1;

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    bf_en;
    logic [M:0]              en_q;
    logic [M:0]              en_d;

    logic signed [WIDTH-1:0] dl_re_q [M];
    logic signed [WIDTH-1:0] dl_im_q [M];
    logic signed [WIDTH-1:0] dl_out_re;
    logic signed [WIDTH-1:0] dl_out_im;
    logic signed [WIDTH-1:0] dl_in_re;
    logic signed [WIDTH-1:0] dl_in_im;

    logic signed [WIDTH-1:0] s_re;
    logic signed [WIDTH-1:0] s_im;
    logic signed [WIDTH-1:0] d_re;
    logic signed [WIDTH-1:0] d_im;

    logic signed [WIDTH-1:0] do_re_q;
    logic signed [WIDTH-1:0] do_im_q;
    logic signed [WIDTH-1:0] do_re_d;
    logic signed [WIDTH-1:0] do_im_d;

    assign dl_out_re = dl_re_q[M-1];
    assign dl_out_im = dl_im_q[M-1];

    sdf_bf_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x0_re_i (dl_out_re),
        .x0_im_i (dl_out_im),
        .x1_re_i (bus.di_re),
        .x1_im_i (bus.di_im),
        .s_re_o  (s_re),
        .s_im_o  (s_im),
        .d_re_o  (d_re),
        .d_im_o  (d_im)
    );

    always_comb begin
        // Counter width gives 2M states, so the natural wrap is 2M-1 -> 0.
        cnt_d = bus.di_en ? cnt_q + CNT_W'(1) : cnt_q;
        bf_en = bus.di_en & cnt_q[CNT_W-1];
        en_d  = {en_q[M-1:0], bus.di_en};

        dl_in_re = bus.di_re;
        dl_in_im = bus.di_im;
        do_re_d  = dl_out_re;
        do_im_d  = dl_out_im;
        if (bf_en) begin
            dl_in_re = d_re;
            dl_in_im = d_im;
            do_re_d  = s_re;
            do_im_d  = s_im;
        end

        // The delay line is never reset, so zero the data whenever the next
        // do_en is low; the output stays X-free and deterministic when idle.
        if (!en_q[M-1]) begin
            do_re_d = '0;
            do_im_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            en_q    <= '0;
            do_re_q <= '0;
            do_im_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            do_re_q <= do_re_d;
            do_im_q <= do_im_d;
        end
    end

    // Feedback delay line shifts every clock regardless of di_en.
    always_ff @(posedge clock) begin
        dl_re_q[0] <= dl_in_re;
        dl_im_q[0] <= dl_in_im;
        for (int unsigned i = 1; i < M; i++) begin
            dl_re_q[i] <= dl_re_q[i-1];
            dl_im_q[i] <= dl_im_q[i-1];
        end
    end

    assign bus.do_en = en_q[M];
    assign bus.do_re = do_re_q;
    assign bus.do_im = do_im_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// tb_sdf_bf_stage: self-checking bench for sdf_bf_stage with M=4, WIDTH=16.
// Each frame's expected output stream is worked out arithmetically from the
// whole input frame and filed by the cycle it must appear in; every cycle the
// bench checks do_en against the presence of an entry and the data against it.
// -----------------------------------------------------------------------------
module tb_sdf_bf_stage;

    localparam int unsigned M = 4;
    localparam int unsigned W = 16;
    localparam int unsigned N = 2 * M;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } samp_t;

    logic clock = 1'b0;
    logic reset_n;

    sdf_bf_stage_if #(.WIDTH(W)) bus ();

    sdf_bf_stage #(
        .M     (M),
        .WIDTH (W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    samp_t exp_q [int];
    int    fr_re [N];
    int    fr_im [N];

    // floor((v + 1) / 2) written with ordinary integer division
    function automatic int half_up(input int v);
        int t;
        t = v + 1;
        if (t >= 0) return t / 2;
        return -((1 - t) / 2);
    endfunction

    function automatic samp_t mk(input int re, input int im);
        samp_t s;
        s.re = W'(re);
        s.im = W'(im);
        return s;
    endfunction

    task automatic check_cycle();
        samp_t e;
        logic  en_exp;
        en_exp = exp_q.exists(cyc);
        checks++;
        assert (bus.do_en === en_exp) else begin
            errors++;
            $error("FAIL do_en cyc=%0d observed=%b expected=%b", cyc, bus.do_en, en_exp);
        end
        if (en_exp) begin
            e = exp_q[cyc];
            checks++;
            assert (bus.do_re === e.re) else begin
                errors++;
                $error("FAIL do_re cyc=%0d observed=%0d expected=%0d",
                       cyc, $signed(bus.do_re), $signed(e.re));
            end
            checks++;
            assert (bus.do_im === e.im) else begin
                errors++;
                $error("FAIL do_im cyc=%0d observed=%0d expected=%0d",
                       cyc, $signed(bus.do_im), $signed(e.im));
            end
            exp_q.delete(cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic drive(input logic en, input int re, input int im);
        bus.di_en = en;
        bus.di_re = W'(re);
        bus.di_im = W'(im);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, int'($urandom), int'($urandom));
    endtask

    // Files the 2M expected outputs of fr_re/fr_im, then streams the frame.
    task automatic send_frame();
        int t0;
        t0 = cyc;
        for (int k = 0; k < int'(M); k++) begin
            exp_q[t0 + M + 1 + k] = mk(half_up(fr_re[k] + fr_re[k+M]),
                                       half_up(fr_im[k] + fr_im[k+M]));
            exp_q[t0 + 2*M + 1 + k] = mk(half_up(fr_re[k] - fr_re[k+M]),
                                         half_up(fr_im[k] - fr_im[k+M]));
        end
        for (int j = 0; j < int'(N); j++) drive(1'b1, fr_re[j], fr_im[j]);
    endtask

    task automatic set_impulse();
        fr_re = '{100, 0, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic set_const();
        for (int i = 0; i < int'(N); i++) begin
            fr_re[i] = 200;
            fr_im[i] = -6;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < int'(N); i++) begin
            fr_re[i] = int'($signed(W'($urandom)));
            fr_im[i] = int'($signed(W'($urandom)));
        end
    endtask

    task automatic check_zero_out(input string tag);
        checks++;
        assert (bus.do_en === 1'b0) else begin
            errors++;
            $error("FAIL %s do_en observed=%b expected=0", tag, bus.do_en);
        end
        checks++;
        assert (bus.do_re === '0) else begin
            errors++;
            $error("FAIL %s do_re observed=%0d expected=0", tag, $signed(bus.do_re));
        end
        checks++;
        assert (bus.do_im === '0) else begin
            errors++;
            $error("FAIL %s do_im observed=%0d expected=0", tag, $signed(bus.do_im));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
        #1;
        check_zero_out("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Impulse
        set_impulse();
        send_frame();
        idle(N + 2);

        // Constant
        set_const();
        send_frame();
        idle(N + 2);

        // Extremes: no wrap at full scale
        fr_re = '{32767, -32768, -3, 0, 32767, 32767, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame();
        idle(N + 2);

        // Back-to-back impulse frames
        set_impulse();
        send_frame();
        send_frame();
        idle(N + 2);

        // Reset mid-frame while the previous frame is still draining
        set_random();
        send_frame();
        for (int j = 0; j < 3; j++) drive(1'b1, 200, -6);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_out("async_reset");
        exp_q.delete();
        bus.di_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        set_const();
        send_frame();
        idle(N + 2);

        // Idle gap between frames
        set_impulse();
        send_frame();
        idle(7);
        set_const();
        send_frame();
        idle(N + 2);

        // Random frames with random gaps (including none)
        for (int f = 0; f < 8; f++) begin
            set_random();
            send_frame();
            idle(int'($urandom_range(0, 3)));
        end
        idle(N + 2);

        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL drained observed=%0d pending expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdf_bf_stage.md
Name: sdf_bf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming R2²SDF FFT pipeline.
- Accepts one complex sample per clock and pairs samples M apart through an internal M-deep feedback delay line.
- Emits sums immediately and buffered differences M cycles later, as one continuous in-order stream.
- Sits directly ahead of the twiddle/next-stage logic. It drives the feedback delay line, which also feeds it back.

Parameters:
- M, 32: butterfly span, i.e. feedback delay depth. Power of two, ≥1. One frame is 2M samples.
- WIDTH, 16: two's-complement width of each real/imag component, input and output.

Ports:
- clock  in  1  master clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- di_en  in  1  input sample valid
- di_re  in  WIDTH  input data, real
- di_im  in  WIDTH  input data, imag
- do_en  out  1  output sample valid
- do_re  out  WIDTH  output data, real (registered)
- do_im  out  WIDTH  output data, imag (registered)

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is the single clock.
- On reset: do_en=0, do_re=0, do_im=0, sample counter=0, enable pipe all 0. Delay-line contents are not reset; do_en masks them.
- Frame rule: di_en is high for 2M contiguous cycles per frame. Gaps of any length are allowed only between frames. Back-to-back frames are legal.
- Counter cnt, width log2(M)+1, increments on each cycle with di_en=1 and wraps 2M-1→0. It holds while di_en=0.
- bf_en = di_en & cnt[MSB], i.e. second half of the frame.
- The delay line shifts every clock, independent of di_en, so its output is the delay-line input from M cycles earlier.
- When bf_en=0:
  - delay-line input = di
  - output mux = delay-line output (previous frame's differences draining)
- When bf_en=1:
  - x0 = delay-line output, x1 = di
  - compute s = x0 + x1 and d = x0 − x1 in WIDTH+1 bits, per component
  - scale both: r = (v + 1) >>> 1, arithmetic, round-half-up, result fits WIDTH exactly
  - delay-line input = scaled d; output mux = scaled s
- The output register captures the mux every clock.
- do_en = di_en delayed by exactly M+1 clocks, via a shift register reset to 0.
- Latency: input sample j of a frame whose first sample arrives at cycle t0 corresponds to output X[j] at cycle t0+M+1+j, for j=0..2M-1.
- Output order: X[0..M-1] = scaled sums, X[M..2M-1] = scaled differences, both in input-pair order.
- Idle cycles (di_en=0): the counter holds, so draining differences still appear on schedule. Garbage written to the delay line during idle is never selected while do_en=1.
- Reset mid-frame: all partial work is discarded, do_en drops immediately (async). The first di_en after release is sample 0 of a new frame.
- do_re/do_im when do_en=0: don't-care for the consumer, but deterministic, with no X propagation after reset.
- A frame with di_en gaps inside it is illegal. No detection is required.

Decomposition:
- Shared package fft_pkg: WIDTH default, and a function for the rounding half-scale ((v+1)>>>1 on WIDTH+1 bits) shared with later stages.
- One natural sub-module, sdf_bf_core: purely combinational complex add/subtract plus scaling. Inputs x0, x1; outputs scaled s and d.
- Counter, delay line, muxes, enable pipe and output register live in the top module.

Test Plan:
- Impulse, M=4, WIDTH=16:
  - Stimulus: frame re=[100,0,0,0,0,0,0,0], im=0, contiguous.
  - Required: do_en high for 8 cycles starting 5 clocks after the first di_en; do_re = 50,0,0,0,50,0,0,0; do_im = 0.
- Constant, M=4:
  - Stimulus: all 8 samples re=200, im=−6.
  - Required: do_re = 200×4 then 0×4; do_im = −6×4 then 0×4 (−12+1 >>> 1 = −6; diff 0).
- Extremes, M=4:
  - Stimulus: first half re=32767, −32768, −3, 0; second half re=32767, 32767, 0, 0.
  - Required: sums 32767, 0, −1, 0; diffs 0, −32767, −1, 0. No wrap.
- Back-to-back frames, M=4:
  - Stimulus: two impulse frames with no gap.
  - Required: do_en continuously high 16 cycles; both frames reproduce the impulse result. Frame-1 differences are not corrupted by frame-2 inputs.
- Reset mid-frame, M=4:
  - Stimulus: pull reset_n low asynchronously after 3 samples; release; send a constant-200 frame.
  - Required: do_en=0 and do_re/do_im=0 immediately on assertion; the new frame gives the constant result with latency 5.
- Idle gap, M=4:
  - Stimulus: impulse frame, then 7 idle cycles, then a constant frame.
  - Required: differences of frame 1 still emitted at cycles t0+9..t0+12; frame 2 output correct with latency 5.
